// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, port ids
// and sizing of the read-latency counter.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int MAX_RD_LATENCY = 4;
    localparam int LAT_CNT_W      = $clog2(MAX_RD_LATENCY);

    typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

    // Counter load value: WAIT lasts RD_LATENCY cycles, ending at count 0.
    function automatic lat_cnt_t lat_reload(input int lat);
        return lat_cnt_t'(lat - 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way grant logic for the RAM arbiter: combinational winner selection
// plus the last_grant history flop used for round-robin tie breaking.
module rr_arb2
    import ram_arbiter_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic grant_en,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_valid = cpu_req | dma_req;
        gnt_id    = PORT_CPU;
        if (cpu_req && dma_req) begin
            // On a tie, round-robin favours whoever did not win last time.
            gnt_id = (FAIR != 0) ? ~last_grant_q : PORT_CPU;
        end else if (dma_req) begin
            gnt_id = PORT_DMA;
        end

        last_grant_d = last_grant_q;
        if (grant_en && gnt_valid) begin
            last_grant_d = gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PORT_DMA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises cpu and dma requests onto the single program/data RAM, one
// strobe at a time, and returns a one-cycle ack (plus read data) per request.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int FAIR       = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,

    output logic [15:0] ram_address_in,
    output logic [15:0] ram_data_out,
    output logic        ram_read_en,
    output logic        ram_write_en,
    input  logic [15:0] ram_data_in,

    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a requester raises req with we/addr/wdata stable and holds it
    // until its ack pulse; req is only sampled in IDLE, so an ack'd request
    // is never served twice and a dropped req does not cancel a latched one.

    state_e      state_q,      state_d;
    logic        winner_q,     winner_d;
    logic        we_q,         we_d;
    logic [15:0] addr_q,       addr_d;
    logic [15:0] wdata_q,      wdata_d;
    lat_cnt_t    cnt_q,        cnt_d;
    logic        cpu_ack_q,    cpu_ack_d;
    logic        dma_ack_q,    dma_ack_d;
    logic [15:0] cpu_rdata_q,  cpu_rdata_d;
    logic [15:0] dma_rdata_q,  dma_rdata_d;
    logic [15:0] ram_addr_q,   ram_addr_d;
    logic [15:0] ram_wdata_q,  ram_wdata_d;
    logic        ram_rd_q,     ram_rd_d;
    logic        ram_wr_q,     ram_wr_d;
    logic        busy_q,       busy_d;

    logic        grant_en;
    logic        gnt_valid;
    logic        gnt_id;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    assign grant_en = (state_q == IDLE);

    rr_arb2 #(
        .FAIR (FAIR)
    ) u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .grant_en  (grant_en),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        sel_we    = (gnt_id == PORT_DMA) ? dma_we    : cpu_we;
        sel_addr  = (gnt_id == PORT_DMA) ? dma_addr  : cpu_addr;
        sel_wdata = (gnt_id == PORT_DMA) ? dma_wdata : cpu_wdata;
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    winner_d   = gnt_id;
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    state_d    = ISSUE;
                    // Strobes are registered, so they are set up on the way into ISSUE.
                    ram_addr_d = sel_addr;
                    if (sel_we) begin
                        ram_wr_d    = 1'b1;
                        ram_wdata_d = sel_wdata;
                    end else begin
                        ram_rd_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d   = DONE;
                    cpu_ack_d = (winner_q == PORT_CPU);
                    dma_ack_d = (winner_q == PORT_DMA);
                end else begin
                    state_d = WAIT;
                    cnt_d   = lat_reload(RD_LATENCY);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (winner_q == PORT_CPU) begin
                        cpu_rdata_d = ram_data_in;
                    end else begin
                        dma_rdata_d = ram_data_in;
                    end
                    state_d   = DONE;
                    cpu_ack_d = (winner_q == PORT_CPU);
                    dma_ack_d = (winner_q == PORT_DMA);
                end else begin
                    cnt_d = cnt_q - lat_cnt_t'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            winner_q    <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_ack        = cpu_ack_q;
    assign dma_ack        = dma_ack_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign dma_rdata      = dma_rdata_q;
    assign ram_address_in = ram_addr_q;
    assign ram_data_out   = ram_wdata_q;
    assign ram_read_en    = ram_rd_q;
    assign ram_write_en   = ram_wr_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;

endmodule
